ckpt_freelist: RTL and testbench

//  Parametrised N-way physical-register free list with branch checkpoints and precise-state flush.

---
 rtl/fl_pkg.sv | 14 +
 rtl/fl_lane_prefix.sv | 23 ++
 rtl/ckpt_freelist.sv | 134 +++++++++++++
 tb/tb_ckpt_freelist.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fl_pkg.sv
// Shared free-list types and default sizing for the rename, retire and rewind paths.
package fl_pkg;

  localparam int FL_WAY      = 3;
  localparam int FL_PR_NUM   = 64;
  localparam int FL_AR_NUM   = 32;
  localparam int FL_CKPT_NUM = 4;
  localparam int FL_DEPTH    = FL_PR_NUM - FL_AR_NUM;

  typedef logic [$clog2(FL_PR_NUM)-1:0]   phy_reg_idx_t;
  typedef logic [$clog2(FL_CKPT_NUM)-1:0] ckpt_tag_t;
  typedef logic [$clog2(FL_DEPTH):0]      fl_ptr_t;

endpackage

// File: rtl/fl_lane_prefix.sv
// Exclusive prefix popcount of a lane mask plus its total; used to compact lanes in order.
module fl_lane_prefix #(
  parameter int WAY = 3,
  localparam int CW = $clog2(WAY + 1)
) (
  input  logic [WAY-1:0]    mask,
  output logic [WAY*CW-1:0] prefix,
  output logic [CW-1:0]     total
);

  logic [CW-1:0] acc;

  always_comb begin
    acc    = '0;
    prefix = '0;
    for (int i = 0; i < WAY; i++) begin
      prefix[i*CW +: CW] = acc;
      acc = acc + CW'(mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/ckpt_freelist.sv
// Physical-register free list with per-branch head checkpoints and flush to the committed head.
module ckpt_freelist
  import fl_pkg::*;
#(
  parameter int WAY      = FL_WAY,
  parameter int PR_NUM   = FL_PR_NUM,
  parameter int AR_NUM   = FL_AR_NUM,
  parameter int CKPT_NUM = FL_CKPT_NUM,
  localparam int DEPTH   = PR_NUM - AR_NUM,
  localparam int PR_W    = $clog2(PR_NUM),
  localparam int PTR_W   = $clog2(DEPTH) + 1,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int CK_W    = $clog2(CKPT_NUM)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [WAY-1:0]      alloc_req,
  output logic                alloc_ok,
  output logic [WAY*PR_W-1:0] alloc_pr,
  output logic [CNT_W-1:0]    free_count,
  input  logic [WAY-1:0]      ret_free,
  input  logic [WAY*PR_W-1:0] ret_told,
  input  logic [WAY-1:0]      ret_commit,
  input  logic                ckpt_take,
  input  logic [CK_W-1:0]     ckpt_tag,
  input  logic                restore_valid,
  input  logic [CK_W-1:0]     restore_tag,
  input  logic                flush
);

  localparam int IDX_W = PTR_W - 1;
  localparam int LW    = $clog2(WAY + 1);
  localparam logic [PTR_W:0] WRAP = (PTR_W+1)'(2 * DEPTH);

  // Pointers live in [0, 2*DEPTH); the extra range distinguishes full from empty.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [LW-1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= WRAP) s = s - WRAP;
    return s[PTR_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] ptr_idx(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] i;
    i = (p >= PTR_W'(DEPTH)) ? p - PTR_W'(DEPTH) : p;
    return i[IDX_W-1:0];
  endfunction

  logic [PR_W-1:0]  entry [DEPTH];
  logic [PTR_W-1:0] head, tail, commit_head;
  logic [PTR_W-1:0] ckpt_head [CKPT_NUM];

  logic [WAY*LW-1:0] a_pre, r_pre;
  logic [LW-1:0]     n_alloc, n_ret, n_commit;
  logic [PTR_W:0]    count_w;
  logic [PTR_W-1:0]  head_nxt, tail_nxt, commit_nxt, alloc_head;
  logic [IDX_W-1:0]  wr_idx [WAY];
  logic              ck_we;

  fl_lane_prefix #(.WAY(WAY)) u_alloc_prefix (
    .mask   (alloc_req),
    .prefix (a_pre),
    .total  (n_alloc)
  );

  fl_lane_prefix #(.WAY(WAY)) u_ret_prefix (
    .mask   (ret_free),
    .prefix (r_pre),
    .total  (n_ret)
  );

  always_comb begin
    count_w = {1'b0, tail} - {1'b0, head};
    if (tail < head) count_w = count_w + WRAP;
    free_count = count_w[CNT_W-1:0];

    // Grants see only registered state; same-cycle frees are not bypassed.
    alloc_ok = !reset && !flush && !restore_valid && ((PTR_W+1)'(n_alloc) <= count_w);
    alloc_pr = '0;
    for (int i = 0; i < WAY; i++) begin
      if (alloc_ok && alloc_req[i])
        alloc_pr[i*PR_W +: PR_W] = entry[ptr_idx(ptr_add(head, a_pre[i*LW +: LW]))];
    end

    n_commit = '0;
    for (int i = 0; i < WAY; i++) n_commit = n_commit + LW'(ret_commit[i]);
    commit_nxt = ptr_add(commit_head, n_commit);

    tail_nxt = ptr_add(tail, n_ret);
    for (int i = 0; i < WAY; i++) wr_idx[i] = ptr_idx(ptr_add(tail, r_pre[i*LW +: LW]));

    alloc_head = alloc_ok ? ptr_add(head, n_alloc) : head;
    ck_we      = ckpt_take && !flush && !restore_valid;

    if (flush)              head_nxt = commit_nxt;
    else if (restore_valid) head_nxt = ckpt_head[restore_tag];
    else                    head_nxt = alloc_head;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head        <= '0;
      tail        <= PTR_W'(DEPTH);
      commit_head <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= PR_W'(AR_NUM + i);
      for (int i = 0; i < CKPT_NUM; i++) ckpt_head[i] <= '0;
    end else begin
      head        <= head_nxt;
      tail        <= tail_nxt;
      commit_head <= commit_nxt;
      if (ck_we) ckpt_head[ckpt_tag] <= alloc_head;
      for (int i = 0; i < WAY; i++) begin
        if (ret_free[i]) entry[wr_idx[i]] <= ret_told[i*PR_W +: PR_W];
      end
    end
  end

`ifndef SYNTHESIS
  logic told_zero;

  always_comb begin
    told_zero = 1'b0;
    for (int i = 0; i < WAY; i++) begin
      if (ret_free[i] && (ret_told[i*PR_W +: PR_W] == '0)) told_zero = 1'b1;
    end
  end

  a_no_free_when_full: assert property (@(posedge clock) disable iff (reset)
    !((count_w == (PTR_W+1)'(DEPTH)) && (|ret_free)));

  a_told_nonzero: assert property (@(posedge clock) disable iff (reset) !told_zero);
`endif

endmodule

// File: tb/tb_ckpt_freelist.sv
// Directed and random checks of ckpt_freelist against an unbounded-log free-list model.
module tb_ckpt_freelist;
  import fl_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  alloc_req;
  logic        alloc_ok;
  logic [17:0] alloc_pr;
  logic [5:0]  free_count;
  logic [2:0]  ret_free;
  logic [17:0] ret_told;
  logic [2:0]  ret_commit;
  logic        ckpt_take;
  logic [1:0]  ckpt_tag;
  logic        restore_valid;
  logic [1:0]  restore_tag;
  logic        flush;

  ckpt_freelist dut (
    .clock         (clock),
    .reset         (reset),
    .alloc_req     (alloc_req),
    .alloc_ok      (alloc_ok),
    .alloc_pr      (alloc_pr),
    .free_count    (free_count),
    .ret_free      (ret_free),
    .ret_told      (ret_told),
    .ret_commit    (ret_commit),
    .ckpt_take     (ckpt_take),
    .ckpt_tag      (ckpt_tag),
    .restore_valid (restore_valid),
    .restore_tag   (restore_tag),
    .flush         (flush)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Model: free list as an append-only log indexed by absolute position.
  int fl[$];
  int m_head, m_tail, m_commit;
  int m_ckpt[4];
  bit m_valid = 1'b0;

  // Soak bookkeeping: which PRs are held by the machine, and where they were allocated.
  int live[64];
  int apos[64];
  int max_fa;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane_pr(input int l);
    phy_reg_idx_t p;
    p = alloc_pr[l*6 +: 6];
    return int'(p);
  endfunction

  task automatic idle();
    alloc_req = '0; ret_free = '0; ret_told = '0; ret_commit = '0;
    ckpt_take = 1'b0; ckpt_tag = '0; restore_valid = 1'b0; restore_tag = '0; flush = 1'b0;
  endtask

  task automatic compare_outputs();
    int cnt, n, k, e;
    bit ok;
    if (!m_valid) return;
    cnt = m_tail - m_head;
    n   = $countones(alloc_req);
    ok  = (n <= cnt) && !flush && !restore_valid && !reset;
    chk("free_count", int'(free_count), cnt);
    chk("alloc_ok", int'(alloc_ok), int'(ok));
    k = 0;
    for (int l = 0; l < 3; l++) begin
      e = 0;
      if (alloc_req[l]) begin
        if (ok) e = fl[m_head + k];
        k++;
      end
      chk($sformatf("alloc_pr[%0d]", l), lane_pr(l), e);
    end
  endtask

  task automatic model_update();
    int n, cnt, nh;
    bit ok;
    if (reset) begin
      fl.delete();
      for (int i = 0; i < 32; i++) fl.push_back(32 + i);
      m_head = 0; m_commit = 0; m_tail = 32;
      for (int i = 0; i < 4; i++) m_ckpt[i] = 0;
      m_valid = 1'b1;
      return;
    end
    n   = $countones(alloc_req);
    cnt = m_tail - m_head;
    ok  = (n <= cnt) && !flush && !restore_valid;
    m_commit += $countones(ret_commit);
    for (int l = 0; l < 3; l++) if (ret_free[l]) fl.push_back(int'(ret_told[l*6 +: 6]));
    m_tail = fl.size();
    if (flush)              nh = m_commit;
    else if (restore_valid) nh = m_ckpt[restore_tag];
    else if (ok)            nh = m_head + n;
    else                    nh = m_head;
    if (ckpt_take && !flush && !restore_valid) m_ckpt[ckpt_tag] = nh;
    m_head = nh;
  endtask

  task automatic settle();
    #2;
    compare_outputs();
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    settle();
    advance();
    reset = 1'b0;
  endtask

  task automatic alloc_n(input logic [2:0] req, input int times);
    for (int i = 0; i < times; i++) begin
      idle();
      alloc_req = req;
      settle();
      advance();
    end
  endtask

  task automatic soak(input int cycles);
    int t, c, room, p, st, k;
    bit found;
    for (int i = 0; i < 64; i++) begin
      live[i] = (i >= 1 && i < 32) ? 1 : 0;
      apos[i] = -1;
    end
    max_fa = -1;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      idle();
      t = 0;
      if ($urandom_range(0, 7) == 0) begin
        t = $urandom_range(0, 3);
        c = m_ckpt[t];
        if (c <= m_head && (m_tail - c) <= 32 && c > max_fa) begin
          restore_valid = 1'b1;
          restore_tag   = 2'(t);
        end
      end
      alloc_req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) begin
        ckpt_take = 1'b1;
        ckpt_tag  = 2'($urandom_range(0, 3));
      end
      if (!restore_valid) begin
        room = 32 - (m_tail - m_head);
        for (int l = 0; l < 3; l++) begin
          if ($urandom_range(0, 1) == 1 && room > 0) begin
            found = 1'b0;
            p  = 0;
            st = $urandom_range(0, 62);
            for (int s = 0; s < 63; s++) begin
              if (!found && live[1 + ((st + s) % 63)] == 1) begin
                found = 1'b1;
                p = 1 + ((st + s) % 63);
              end
            end
            if (found) begin
              ret_free[l] = 1'b1;
              ret_told[l*6 +: 6] = 6'(p);
              live[p] = 0;
              if (apos[p] > max_fa) max_fa = apos[p];
              room--;
            end
          end
        end
      end
      settle();
      k = 0;
      for (int l = 0; l < 3; l++) begin
        if (alloc_req[l]) begin
          if (alloc_ok) begin
            p = lane_pr(l);
            chk("soak_no_pr0", int'(p != 0), 1);
            chk("soak_no_dup", live[p], 0);
            live[p] = 1;
            apos[p] = m_head + k;
          end
          k++;
        end
      end
      if (restore_valid) begin
        for (int pos = m_ckpt[restore_tag]; pos < m_head; pos++) live[fl[pos]] = 0;
      end
      chk("soak_count_range", int'(free_count <= 6'd32), 1);
      advance();
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;

    // Reset with requests pending: nothing granted, then full free list.
    alloc_req = 3'b111;
    settle();
    chk("reset_alloc_ok", int'(alloc_ok), 0);
    chk("reset_alloc_pr", int'(alloc_pr), 0);
    advance();
    reset = 1'b0;

    idle();
    alloc_req = 3'b111;
    settle();
    chk("t1_free_count", int'(free_count), 32);
    chk("t1_ok", int'(alloc_ok), 1);
    chk("t1_lane0", lane_pr(0), 32);
    chk("t1_lane1", lane_pr(1), 33);
    chk("t1_lane2", lane_pr(2), 34);
    advance();
    idle();
    settle();
    chk("t1_after_count", int'(free_count), 29);
    advance();

    // Sparse lanes compact in order.
    do_reset();
    alloc_req = 3'b101;
    settle();
    chk("t2_lane0", lane_pr(0), 32);
    chk("t2_lane1", lane_pr(1), 0);
    chk("t2_lane2", lane_pr(2), 33);
    advance();
    idle();
    alloc_req = 3'b001;
    settle();
    chk("t2_next_count", int'(free_count), 30);
    chk("t2_next_lane0", lane_pr(0), 34);
    advance();

    // Near-empty: all-or-nothing refusal, free lands next cycle and is reused.
    do_reset();
    alloc_n(3'b111, 10);
    idle();
    alloc_req = 3'b111;
    ret_free  = 3'b001;
    ret_told[5:0] = 6'd5;
    settle();
    chk("t3_count2", int'(free_count), 2);
    chk("t3_refused", int'(alloc_ok), 0);
    chk("t3_pr_zero", int'(alloc_pr), 0);
    advance();
    idle();
    alloc_req = 3'b111;
    settle();
    chk("t3_count3", int'(free_count), 3);
    chk("t3_ok", int'(alloc_ok), 1);
    chk("t3_lane0", lane_pr(0), 62);
    chk("t3_lane1", lane_pr(1), 63);
    chk("t3_lane2", lane_pr(2), 5);
    advance();
    idle();
    settle();
    chk("t3_empty", int'(free_count), 0);
    advance();

    // Checkpoint then restore.
    do_reset();
    alloc_req = 3'b011;
    ckpt_take = 1'b1;
    ckpt_tag  = 2'd1;
    settle();
    advance();
    alloc_n(3'b111, 2);
    idle();
    restore_valid = 1'b1;
    restore_tag   = 2'd1;
    alloc_req     = 3'b111;
    ckpt_take     = 1'b1;
    ckpt_tag      = 2'd1;
    settle();
    chk("t4_restore_blocks", int'(alloc_ok), 0);
    advance();
    idle();
    alloc_req = 3'b001;
    settle();
    chk("t4_count", int'(free_count), 30);
    chk("t4_lane0", lane_pr(0), 34);
    advance();

    // Flush to committed head, winning over a same-cycle restore.
    do_reset();
    alloc_n(3'b111, 1);
    idle();
    alloc_req  = 3'b111;
    ret_commit = 3'b111;
    settle();
    advance();
    idle();
    alloc_req  = 3'b111;
    ret_commit = 3'b001;
    settle();
    advance();
    idle();
    flush         = 1'b1;
    restore_valid = 1'b1;
    restore_tag   = 2'd0;
    ret_commit    = 3'b001;
    alloc_req     = 3'b001;
    settle();
    chk("t5_flush_blocks", int'(alloc_ok), 0);
    advance();
    idle();
    alloc_req = 3'b001;
    settle();
    chk("t5_count", int'(free_count), 27);
    chk("t5_lane0", lane_pr(0), 37);
    advance();

    do_reset();
    soak(200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
